mono_hit_filter: RTL and testbench
==================================

# mono_hit_filter

Downstream consumer of the MONOPIX hit-receiver output FIFO. Pops 32-bit hit words (ID, le, te, row, col), computes time-over-threshold with 8-bit wrap-around, drops hits outside a programmable ToT window, and repacks survivors into a ToT-tagged word. Presents survivors through a first-word-fall-through FIFO port to the readout arbiter.

## Interface
- `ID_PASS` (default 1): 1 = carry input bits [31:30] into output; 0 = force output [31:30] to 2'b00.
- `BUS_CLK` in 1: single clock, same domain as the receiver's FIFO side.
- `RST_N` in 1: reset, asynchronous, active-low.
- `IN_FIFO_EMPTY` in 1: upstream FIFO empty.
- `IN_FIFO_DATA` in 32: upstream head word.
  - FWFT: valid whenever `IN_FIFO_EMPTY`=0.
  - Layout: [31:30] ID, [29:22] le, [21:14] te, [13:6] row, [5:0] col (binary; upstream gray decode must be enabled).
- `IN_FIFO_READ` out 1: pop strobe, combinational.
- `CONF_EN` in 1: 1 = apply ToT window; 0 = forward all words.
- `CONF_TOT_MIN` in 8: inclusive lower ToT bound.
- `CONF_TOT_MAX` in 8: inclusive upper ToT bound.
- `OUT_FIFO_READ` in 1: downstream pop.
- `OUT_FIFO_EMPTY` out 1: output buffer empty.
- `OUT_FIFO_DATA` out 32: output head word, FWFT.
  - Layout: [31:30] ID, [29:22] tot, [21:14] le, [13:6] row, [5:0] col.
- `HIT_CNT` out 16: words popped, saturating.
- `DROP_CNT` out 16: words dropped, saturating.

## Operation
- Three-step datapath:
  - S1: capture the popped word.
  - S2: compute `tot = te - le` mod 256, evaluate keep, register.
  - OBUF: 4-entry FWFT buffer.
- Admission:
  - `IN_FIFO_READ = !IN_FIFO_EMPTY && (obuf_count + v_s1 + v_s2) < 4`.
  - No word is ever lost on a full buffer.
- Wrap-around: le=250, te=4 gives tot=10. te==le gives tot=0.
- Keep rule when `CONF_EN`=1:
  - Keep when `CONF_TOT_MIN <= tot <= CONF_TOT_MAX`, unsigned.
  - If MIN > MAX, every word is dropped.
- Keep rule when `CONF_EN`=0: every word is kept.
- Config ports are sampled at S2 and may change at any time. A change affects only words that have not yet passed S2.
- Counters:
  - `HIT_CNT` increments on each pop.
  - `DROP_CNT` increments when S2 discards a word.
  - Both stop at 0xFFFF.
  - Cleared only by reset.
- OBUF rules:
  - Simultaneous write and `OUT_FIFO_READ` leaves the count unchanged.
  - `OUT_FIFO_READ` while empty is ignored.

## Timing
- Reset values:
  - `IN_FIFO_READ`=0
  - `OUT_FIFO_EMPTY`=1
  - `OUT_FIFO_DATA`=0
  - `HIT_CNT`=0, `DROP_CNT`=0
  - All valid flags = 0
- Latency: a pop in cycle N gives S1 valid at N+1 and S2 valid at N+2. A kept word makes `OUT_FIFO_EMPTY` fall at N+3.
- Throughput: one word per cycle sustained while downstream pops every cycle.
- Reset asserted mid-operation:
  - In-flight and buffered words are discarded.
  - `IN_FIFO_READ` drops immediately, asynchronously.
- Release is synchronised internally with a two-flop deassert, so the first pop happens no earlier than the second `BUS_CLK` edge after `RST_N` rises.

## Configuration
- Macro `MONO_HIT_FILTER_COL_MASK_EN`:
  - Defined: adds input `CONF_COL_MASK` [63:0]. S2 drops a word when `CONF_COL_MASK[col]`=1, regardless of `CONF_EN`, and counts it in `DROP_CNT`.
  - Undefined: the port is absent and there is no column filtering.

## Structure
- Package `mono_hit_pkg` holds:
  - input field offsets and widths: LE, TE, ROW, COL, ID;
  - output field offsets and widths;
  - constant `OBUF_DEPTH` = 4;
  - counter width 16.
- Sub-module `mono_hit_obuf`:
  - 4-entry FWFT FIFO with count output;
  - clocked by `BUS_CLK`, reset by `RST_N`.
- Top level contains S1/S2, the ToT arithmetic, the keep rule and the counters.

## Test plan
- Reset then idle: `OUT_FIFO_EMPTY`=1, both counters 0, no `IN_FIFO_READ` pulses.
- `CONF_EN`=1, MIN=5, MAX=20; words (le=250, te=4), (le=10, te=10), (le=3, te=30).
  - Output: one word with tot=10.
  - `HIT_CNT`=3, `DROP_CNT`=2.
- Backpressure: `OUT_FIFO_READ` held 0, 10 words offered.
  - Exactly 4 are popped; `IN_FIFO_READ` stays 0 afterwards.
  - Releasing `OUT_FIFO_READ` drains all 10 in order with no loss or duplication.
- `CONF_EN`=0, 300 words popped back-to-back: all forwarded at 1 word/cycle. Repeated runs without reset saturate `HIT_CNT` at 0xFFFF.
- `RST_N` pulsed with 3 words buffered: `OUT_FIFO_EMPTY`=1 asynchronously, counters 0, and the next output is the next upstream word.
- With `MONO_HIT_FILTER_COL_MASK_EN` defined and `CONF_COL_MASK[7]`=1, `CONF_EN`=0: a word with col=7 is dropped (`DROP_CNT`=1) and col=8 passes.

Source files
------------

// File: rtl/mono_hit_pkg.sv
// Shared field map, sizes and ToT helper for the MONOPIX hit filter.
// Latency: n/a (package).
// Backpressure: n/a (package).
package mono_hit_pkg;

    localparam int WORD_W      = 32;

    // Field widths, common to input and output words
    localparam int ID_W        = 2;
    localparam int LE_W        = 8;
    localparam int TE_W        = 8;
    localparam int ROW_W       = 8;
    localparam int COL_W       = 6;
    localparam int TOT_W       = 8;

    // Input word: {id, le, te, row, col}
    localparam int IN_ID_LSB   = 30;
    localparam int IN_LE_LSB   = 22;
    localparam int IN_TE_LSB   = 14;
    localparam int IN_ROW_LSB  = 6;
    localparam int IN_COL_LSB  = 0;

    // Output word: {id, tot, le, row, col}
    localparam int OUT_ID_LSB  = 30;
    localparam int OUT_TOT_LSB = 22;
    localparam int OUT_LE_LSB  = 14;
    localparam int OUT_ROW_LSB = 6;
    localparam int OUT_COL_LSB = 0;

    localparam int OBUF_DEPTH  = 4;
    localparam int OBUF_CNT_W  = 3;
    localparam int CNT_W       = 16;

    // Time-over-threshold of an 8-bit timestamp pair; wraps modulo 256.
    function automatic logic [TOT_W-1:0] calc_tot(input logic [LE_W-1:0] le,
                                                  input logic [TE_W-1:0] te);
        return TOT_W'(te - le);
    endfunction

endpackage

// File: rtl/mono_hit_obuf.sv
// Small first-word-fall-through FIFO with occupancy output.
// Latency: a write is visible at the head on the cycle after it is accepted.
// Backpressure: writes when full are ignored unless a read frees a slot the same cycle; reads when empty are ignored.
module mono_hit_obuf #(
    parameter int DEPTH = 4,
    parameter int DAT_W = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_vld,
    input  logic [DAT_W-1:0]         i_wr_dat,
    input  logic                     i_rd,
    output logic                     o_empty,
    output logic [DAT_W-1:0]         o_rd_dat,
    output logic [$clog2(DEPTH):0]   o_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Pointers wrap naturally, so DEPTH must be a power of two.
    logic [DAT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_cnt;

    logic             w_rd_en;
    logic             w_wr_en;

    assign w_rd_en  = i_rd && (r_cnt != '0);
    assign w_wr_en  = i_wr_vld && ((r_cnt != CW'(DEPTH)) || w_rd_en);

    assign o_empty  = (r_cnt == '0);
    assign o_rd_dat = r_mem[r_rd_ptr];
    assign o_cnt    = r_cnt;

    // Storage; cleared on reset so the head reads zero while empty
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end

    // Read/write pointers and occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/mono_hit_filter.sv
// Pops hit words, computes ToT (te-le mod 256), drops words outside the ToT window, repacks survivors. Optional column mask: MONO_HIT_FILTER_COL_MASK_EN.
// Latency: pop in cycle N -> S1 valid N+1 -> S2 valid N+2 -> OUT_FIFO_EMPTY falls N+3.
// Backpressure: pops only while buffered + in-flight words < 4, so a full output buffer never loses a word.
module mono_hit_filter
    import mono_hit_pkg::*;
#(
    parameter int ID_PASS = 1
) (
    input  logic                BUS_CLK,
    input  logic                RST_N,
    input  logic                IN_FIFO_EMPTY,
    input  logic [WORD_W-1:0]   IN_FIFO_DATA,
    output logic                IN_FIFO_READ,
    input  logic                CONF_EN,
    input  logic [TOT_W-1:0]    CONF_TOT_MIN,
    input  logic [TOT_W-1:0]    CONF_TOT_MAX,
`ifdef MONO_HIT_FILTER_COL_MASK_EN
    input  logic [63:0]         CONF_COL_MASK,
`endif
    input  logic                OUT_FIFO_READ,
    output logic                OUT_FIFO_EMPTY,
    output logic [WORD_W-1:0]   OUT_FIFO_DATA,
    output logic [CNT_W-1:0]    HIT_CNT,
    output logic [CNT_W-1:0]    DROP_CNT
);

    logic [1:0]             r_rst_sync;
    logic                   r_s1_vld;
    logic [WORD_W-1:0]      r_s1_dat;
    logic                   r_s2_vld;
    logic [WORD_W-1:0]      r_s2_dat;
    logic [CNT_W-1:0]       r_hit_cnt;
    logic [CNT_W-1:0]       r_drop_cnt;

    logic [OBUF_CNT_W-1:0]  w_obuf_cnt;
    logic [3:0]             w_occ;
    logic [ID_W-1:0]        w_id;
    logic [LE_W-1:0]        w_le;
    logic [TE_W-1:0]        w_te;
    logic [ROW_W-1:0]       w_row;
    logic [COL_W-1:0]       w_col;
    logic [TOT_W-1:0]       w_tot;
    logic                   w_in_win;
    logic                   w_col_ok;
    logic                   w_keep;
    logic                   w_drop;
    logic [WORD_W-1:0]      w_out_dat;

    // Reset release is resynchronised; assertion clears it asynchronously
    always_ff @(posedge BUS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    // Reserve a buffer slot for every word already in S1/S2, even if it may be dropped
    assign w_occ        = 4'(w_obuf_cnt) + {3'b000, r_s1_vld} + {3'b000, r_s2_vld};
    assign IN_FIFO_READ = r_rst_sync[1] && !IN_FIFO_EMPTY && (w_occ < 4'(OBUF_DEPTH));

    // S1: capture the popped word
    always_ff @(posedge BUS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1_vld <= 1'b0;
            r_s1_dat <= '0;
        end else begin
            r_s1_vld <= IN_FIFO_READ;
            if (IN_FIFO_READ) begin
                r_s1_dat <= IN_FIFO_DATA;
            end
        end
    end

    assign w_id  = (ID_PASS != 0) ? r_s1_dat[IN_ID_LSB +: ID_W] : '0;
    assign w_le  = r_s1_dat[IN_LE_LSB  +: LE_W];
    assign w_te  = r_s1_dat[IN_TE_LSB  +: TE_W];
    assign w_row = r_s1_dat[IN_ROW_LSB +: ROW_W];
    assign w_col = r_s1_dat[IN_COL_LSB +: COL_W];
    assign w_tot = calc_tot(w_le, w_te);

    // MIN > MAX yields an empty window, so every word is dropped
    assign w_in_win = (w_tot >= CONF_TOT_MIN) && (w_tot <= CONF_TOT_MAX);

`ifdef MONO_HIT_FILTER_COL_MASK_EN
    assign w_col_ok = !CONF_COL_MASK[w_col];
`else
    assign w_col_ok = 1'b1;
`endif

    assign w_keep = (!CONF_EN || w_in_win) && w_col_ok;
    assign w_drop = r_s1_vld && !w_keep;

    // Repack a surviving word as {id, tot, le, row, col}
    always_comb begin
        w_out_dat = '0;
        w_out_dat[OUT_ID_LSB  +: ID_W]  = w_id;
        w_out_dat[OUT_TOT_LSB +: TOT_W] = w_tot;
        w_out_dat[OUT_LE_LSB  +: LE_W]  = w_le;
        w_out_dat[OUT_ROW_LSB +: ROW_W] = w_row;
        w_out_dat[OUT_COL_LSB +: COL_W] = w_col;
    end

    // S2: register kept words; config is sampled here
    always_ff @(posedge BUS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s2_vld <= 1'b0;
            r_s2_dat <= '0;
        end else begin
            r_s2_vld <= r_s1_vld && w_keep;
            if (r_s1_vld && w_keep) begin
                r_s2_dat <= w_out_dat;
            end
        end
    end

    // Saturating hit and drop counters
    always_ff @(posedge BUS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_hit_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (IN_FIFO_READ && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            end
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign HIT_CNT  = r_hit_cnt;
    assign DROP_CNT = r_drop_cnt;

    mono_hit_obuf #(
        .DEPTH (OBUF_DEPTH),
        .DAT_W (WORD_W)
    ) u_obuf (
        .i_clk    (BUS_CLK),
        .i_rst_n  (RST_N),
        .i_wr_vld (r_s2_vld),
        .i_wr_dat (r_s2_dat),
        .i_rd     (OUT_FIFO_READ),
        .o_empty  (OUT_FIFO_EMPTY),
        .o_rd_dat (OUT_FIFO_DATA),
        .o_cnt    (w_obuf_cnt)
    );

endmodule

// File: tb/tb_mono_hit_filter.sv
// Directed bench for mono_hit_filter: upstream FWFT FIFO model plus hand-computed expected words.
// Latency: checks exact pop/empty timing relative to reset release and pops.
// Backpressure: holds OUT_FIFO_READ low to fill the buffer, then drains.
module tb_mono_hit_filter;

    logic        BUS_CLK;
    logic        RST_N;
    logic        IN_FIFO_EMPTY;
    logic [31:0] IN_FIFO_DATA;
    logic        IN_FIFO_READ;
    logic        CONF_EN;
    logic [7:0]  CONF_TOT_MIN;
    logic [7:0]  CONF_TOT_MAX;
`ifdef MONO_HIT_FILTER_COL_MASK_EN
    logic [63:0] CONF_COL_MASK;
`endif
    logic        OUT_FIFO_READ;
    logic        OUT_FIFO_EMPTY;
    logic [31:0] OUT_FIFO_DATA;
    logic [15:0] HIT_CNT;
    logic [15:0] DROP_CNT;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pop_cnt = 0;
    int first_pop = 0;
    int last_pop = 0;

    logic [31:0] up_q[$];
    logic [31:0] rx_q[$];
    int          rx_cyc[$];
    logic [31:0] exp_q[$];

    mono_hit_filter dut (
        .BUS_CLK        (BUS_CLK),
        .RST_N          (RST_N),
        .IN_FIFO_EMPTY  (IN_FIFO_EMPTY),
        .IN_FIFO_DATA   (IN_FIFO_DATA),
        .IN_FIFO_READ   (IN_FIFO_READ),
        .CONF_EN        (CONF_EN),
        .CONF_TOT_MIN   (CONF_TOT_MIN),
        .CONF_TOT_MAX   (CONF_TOT_MAX),
`ifdef MONO_HIT_FILTER_COL_MASK_EN
        .CONF_COL_MASK  (CONF_COL_MASK),
`endif
        .OUT_FIFO_READ  (OUT_FIFO_READ),
        .OUT_FIFO_EMPTY (OUT_FIFO_EMPTY),
        .OUT_FIFO_DATA  (OUT_FIFO_DATA),
        .HIT_CNT        (HIT_CNT),
        .DROP_CNT       (DROP_CNT)
    );

    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    function automatic logic [31:0] in_w(input logic [1:0] id, input logic [7:0] le,
                                         input logic [7:0] te, input logic [7:0] row,
                                         input logic [5:0] col);
        return {id, le, te, row, col};
    endfunction

    function automatic logic [31:0] out_w(input logic [1:0] id, input logic [7:0] tot,
                                          input logic [7:0] le, input logic [7:0] row,
                                          input logic [5:0] col);
        return {id, tot, le, row, col};
    endfunction

    task automatic refresh_up();
        IN_FIFO_EMPTY = (up_q.size() == 0);
        IN_FIFO_DATA  = (up_q.size() == 0) ? 32'h0 : up_q[0];
        #1;
    endtask

    // One clock: sample handshakes mid-cycle, cross the edge, update upstream model
    task automatic step();
        logic        pop;
        logic [31:0] tmp;
        pop = IN_FIFO_READ;
        if (OUT_FIFO_READ && !OUT_FIFO_EMPTY) begin
            rx_q.push_back(OUT_FIFO_DATA);
            rx_cyc.push_back(cyc);
        end
        if (pop) begin
            if (pop_cnt == 0) first_pop = cyc;
            last_pop = cyc;
            pop_cnt++;
        end
        @(posedge BUS_CLK);
        #1;
        if (pop && (up_q.size() > 0)) tmp = up_q.pop_front();
        cyc++;
        refresh_up();
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        OUT_FIFO_READ = 1'b0;
        up_q.delete();
        rx_q.delete();
        rx_cyc.delete();
        exp_q.delete();
        refresh_up();
        step();
        step();
        RST_N = 1'b1;
        #1;
        repeat (3) step();
        pop_cnt = 0;
    endtask

    task automatic test_reset();
        logic [31:0] w;
        checks++; if (IN_FIFO_READ !== 1'b0) begin errors++; $display("FAIL rst_read: got %b expected 0", IN_FIFO_READ); end
        checks++; if (OUT_FIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", OUT_FIFO_EMPTY); end
        checks++; if (OUT_FIFO_DATA !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", OUT_FIFO_DATA); end
        checks++; if (HIT_CNT !== 16'h0) begin errors++; $display("FAIL rst_hit: got %h expected 0", HIT_CNT); end
        checks++; if (DROP_CNT !== 16'h0) begin errors++; $display("FAIL rst_drop: got %h expected 0", DROP_CNT); end
        step();
        step();
        RST_N = 1'b1;
        #1;
        pop_cnt = 0;
        repeat (10) step();
        checks++; if (pop_cnt !== 0) begin errors++; $display("FAIL idle_pops: got %0d expected 0", pop_cnt); end

        // Release timing and pop-to-output latency
        RST_N = 1'b0;
        #1;
        w = in_w(2'd2, 8'd100, 8'd130, 8'd55, 6'd33);
        up_q.push_back(w);
        refresh_up();
        step();
        RST_N = 1'b1;
        #1;
        step();
        checks++; if (IN_FIFO_READ !== 1'b0) begin errors++; $display("FAIL sync_edge1: got %b expected 0", IN_FIFO_READ); end
        step();
        checks++; if (IN_FIFO_READ !== 1'b1) begin errors++; $display("FAIL sync_edge2: got %b expected 1", IN_FIFO_READ); end
        step();
        checks++; if (OUT_FIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL lat_n1: got %b expected 1", OUT_FIFO_EMPTY); end
        step();
        checks++; if (OUT_FIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL lat_n2: got %b expected 1", OUT_FIFO_EMPTY); end
        step();
        checks++; if (OUT_FIFO_EMPTY !== 1'b0) begin errors++; $display("FAIL lat_n3: got %b expected 0", OUT_FIFO_EMPTY); end
        checks++; if (OUT_FIFO_DATA !== out_w(2'd2, 8'd30, 8'd100, 8'd55, 6'd33)) begin errors++; $display("FAIL lat_data: got %h expected %h", OUT_FIFO_DATA, out_w(2'd2, 8'd30, 8'd100, 8'd55, 6'd33)); end
        OUT_FIFO_READ = 1'b1;
        step();
        OUT_FIFO_READ = 1'b0;
        checks++; if (OUT_FIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL lat_popped: got %b expected 1", OUT_FIFO_EMPTY); end
        checks++; if (HIT_CNT !== 16'd1) begin errors++; $display("FAIL lat_hit: got %0d expected 1", HIT_CNT); end
    endtask

    task automatic test_window();
        logic [31:0] e;
        do_reset();
        CONF_EN = 1'b1; CONF_TOT_MIN = 8'd5; CONF_TOT_MAX = 8'd20;
        OUT_FIFO_READ = 1'b1;
        up_q.push_back(in_w(2'd1, 8'd250, 8'd4,  8'd10, 6'd5));
        up_q.push_back(in_w(2'd2, 8'd10,  8'd10, 8'd11, 6'd6));
        up_q.push_back(in_w(2'd3, 8'd3,   8'd30, 8'd12, 6'd7));
        refresh_up();
        repeat (15) step();
        e = out_w(2'd1, 8'd10, 8'd250, 8'd10, 6'd5);
        checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL win_count: got %0d expected 1", rx_q.size()); end
        if (rx_q.size() > 0) begin
            checks++; if (rx_q[0] !== e) begin errors++; $display("FAIL win_word: got %h expected %h", rx_q[0], e); end
        end
        checks++; if (HIT_CNT !== 16'd3) begin errors++; $display("FAIL win_hit: got %0d expected 3", HIT_CNT); end
        checks++; if (DROP_CNT !== 16'd2) begin errors++; $display("FAIL win_drop: got %0d expected 2", DROP_CNT); end
    endtask

    task automatic test_bounds();
        logic [31:0] e0, e1;
        do_reset();
        CONF_EN = 1'b1; CONF_TOT_MIN = 8'd5; CONF_TOT_MAX = 8'd20;
        OUT_FIFO_READ = 1'b1;
        up_q.push_back(in_w(2'd0, 8'd0,   8'd4,   8'd1, 6'd1));
        up_q.push_back(in_w(2'd1, 8'd100, 8'd105, 8'd2, 6'd2));
        up_q.push_back(in_w(2'd2, 8'd240, 8'd4,   8'd3, 6'd3));
        up_q.push_back(in_w(2'd3, 8'd0,   8'd21,  8'd4, 6'd4));
        refresh_up();
        repeat (15) step();
        CONF_TOT_MIN = 8'd9; CONF_TOT_MAX = 8'd8;
        up_q.push_back(in_w(2'd1, 8'd1, 8'd9,  8'd5, 6'd5));
        up_q.push_back(in_w(2'd1, 8'd1, 8'd10, 8'd6, 6'd6));
        refresh_up();
        repeat (15) step();
        e0 = out_w(2'd1, 8'd5,  8'd100, 8'd2, 6'd2);
        e1 = out_w(2'd2, 8'd20, 8'd240, 8'd3, 6'd3);
        checks++; if (rx_q.size() !== 2) begin errors++; $display("FAIL bnd_count: got %0d expected 2", rx_q.size()); end
        if (rx_q.size() > 1) begin
            checks++; if (rx_q[0] !== e0) begin errors++; $display("FAIL bnd_min: got %h expected %h", rx_q[0], e0); end
            checks++; if (rx_q[1] !== e1) begin errors++; $display("FAIL bnd_max: got %h expected %h", rx_q[1], e1); end
        end
        checks++; if (HIT_CNT !== 16'd6) begin errors++; $display("FAIL bnd_hit: got %0d expected 6", HIT_CNT); end
        checks++; if (DROP_CNT !== 16'd4) begin errors++; $display("FAIL bnd_drop: got %0d expected 4", DROP_CNT); end
    endtask

    task automatic test_backpressure();
        do_reset();
        CONF_EN = 1'b0;
        OUT_FIFO_READ = 1'b0;
        for (int i = 0; i < 10; i++) begin
            up_q.push_back(in_w(2'(i), 8'(i * 3), 8'(i * 3 + 7), 8'(i), 6'(i + 1)));
            exp_q.push_back(out_w(2'(i), 8'd7, 8'(i * 3), 8'(i), 6'(i + 1)));
        end
        refresh_up();
        repeat (20) step();
        checks++; if (pop_cnt !== 4) begin errors++; $display("FAIL bp_pops: got %0d expected 4", pop_cnt); end
        checks++; if (IN_FIFO_READ !== 1'b0) begin errors++; $display("FAIL bp_read: got %b expected 0", IN_FIFO_READ); end
        checks++; if (up_q.size() !== 6) begin errors++; $display("FAIL bp_left: got %0d expected 6", up_q.size()); end
        OUT_FIFO_READ = 1'b1;
        repeat (30) step();
        checks++; if (rx_q.size() !== 10) begin errors++; $display("FAIL bp_count: got %0d expected 10", rx_q.size()); end
        for (int i = 0; i < 10; i++) begin
            if (i < rx_q.size()) begin
                checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
            end
        end
        checks++; if (HIT_CNT !== 16'd10) begin errors++; $display("FAIL bp_hit: got %0d expected 10", HIT_CNT); end
    endtask

    task automatic test_back_to_back();
        int bad;
        do_reset();
        CONF_EN = 1'b0;
        OUT_FIFO_READ = 1'b1;
        for (int i = 0; i < 300; i++) begin
            up_q.push_back(in_w(2'(i), 8'(i), 8'(i + 3), 8'(i * 7), 6'(i)));
            exp_q.push_back(out_w(2'(i), 8'd3, 8'(i), 8'(i * 7), 6'(i)));
        end
        refresh_up();
        repeat (320) step();
        checks++; if (pop_cnt !== 300) begin errors++; $display("FAIL b2b_pops: got %0d expected 300", pop_cnt); end
        checks++; if (last_pop - first_pop !== 299) begin errors++; $display("FAIL b2b_pop_span: got %0d expected 299", last_pop - first_pop); end
        checks++; if (rx_q.size() !== 300) begin errors++; $display("FAIL b2b_count: got %0d expected 300", rx_q.size()); end
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            if ((i >= rx_q.size()) || (rx_q[i] !== exp_q[i])) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_words: got %0d bad words expected 0", bad); end
        if (rx_cyc.size() == 300) begin
            checks++; if (rx_cyc[299] - rx_cyc[0] !== 299) begin errors++; $display("FAIL b2b_out_span: got %0d expected 299", rx_cyc[299] - rx_cyc[0]); end
        end
        checks++; if (HIT_CNT !== 16'd300) begin errors++; $display("FAIL b2b_hit: got %0d expected 300", HIT_CNT); end
    endtask

    task automatic test_async_reset();
        logic [31:0] e;
        do_reset();
        CONF_EN = 1'b0;
        OUT_FIFO_READ = 1'b0;
        up_q.push_back(in_w(2'd1, 8'd1, 8'd2, 8'd1, 6'd1));
        up_q.push_back(in_w(2'd1, 8'd2, 8'd4, 8'd2, 6'd2));
        up_q.push_back(in_w(2'd1, 8'd3, 8'd6, 8'd3, 6'd3));
        refresh_up();
        repeat (8) step();
        checks++; if (OUT_FIFO_EMPTY !== 1'b0) begin errors++; $display("FAIL ar_filled: got %b expected 0", OUT_FIFO_EMPTY); end
        up_q.push_back(in_w(2'd3, 8'd40, 8'd52, 8'd77, 6'd21));
        refresh_up();
        RST_N = 1'b0;
        #1;
        checks++; if (OUT_FIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL ar_empty: got %b expected 1", OUT_FIFO_EMPTY); end
        checks++; if (IN_FIFO_READ !== 1'b0) begin errors++; $display("FAIL ar_read: got %b expected 0", IN_FIFO_READ); end
        checks++; if (HIT_CNT !== 16'd0) begin errors++; $display("FAIL ar_hit: got %0d expected 0", HIT_CNT); end
        checks++; if (OUT_FIFO_DATA !== 32'h0) begin errors++; $display("FAIL ar_data: got %h expected 0", OUT_FIFO_DATA); end
        step();
        step();
        RST_N = 1'b1;
        #1;
        OUT_FIFO_READ = 1'b1;
        repeat (10) step();
        e = out_w(2'd3, 8'd12, 8'd40, 8'd77, 6'd21);
        checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL ar_count: got %0d expected 1", rx_q.size()); end
        if (rx_q.size() > 0) begin
            checks++; if (rx_q[0] !== e) begin errors++; $display("FAIL ar_word: got %h expected %h", rx_q[0], e); end
        end
        checks++; if (HIT_CNT !== 16'd1) begin errors++; $display("FAIL ar_hit_after: got %0d expected 1", HIT_CNT); end
    endtask

    task automatic test_saturation();
        do_reset();
        CONF_EN = 1'b1; CONF_TOT_MIN = 8'd9; CONF_TOT_MAX = 8'd8;
        IN_FIFO_DATA  = in_w(2'd0, 8'd1, 8'd2, 8'd3, 6'd4);
        IN_FIFO_EMPTY = 1'b0;
        repeat (65600) @(posedge BUS_CLK);
        #1;
        IN_FIFO_EMPTY = 1'b1;
        #1;
        checks++; if (HIT_CNT !== 16'hFFFF) begin errors++; $display("FAIL sat_hit: got %h expected ffff", HIT_CNT); end
        checks++; if (DROP_CNT !== 16'hFFFF) begin errors++; $display("FAIL sat_drop: got %h expected ffff", DROP_CNT); end
        checks++; if (OUT_FIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL sat_empty: got %b expected 1", OUT_FIFO_EMPTY); end
    endtask

`ifdef MONO_HIT_FILTER_COL_MASK_EN
    task automatic test_col_mask();
        logic [31:0] e;
        do_reset();
        CONF_EN = 1'b0;
        CONF_COL_MASK = 64'd1 << 7;
        OUT_FIFO_READ = 1'b1;
        up_q.push_back(in_w(2'd1, 8'd10, 8'd20, 8'd9, 6'd7));
        up_q.push_back(in_w(2'd2, 8'd10, 8'd20, 8'd9, 6'd8));
        refresh_up();
        repeat (12) step();
        e = out_w(2'd2, 8'd10, 8'd10, 8'd9, 6'd8);
        checks++; if (DROP_CNT !== 16'd1) begin errors++; $display("FAIL cm_drop: got %0d expected 1", DROP_CNT); end
        checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL cm_count: got %0d expected 1", rx_q.size()); end
        if (rx_q.size() > 0) begin
            checks++; if (rx_q[0] !== e) begin errors++; $display("FAIL cm_word: got %h expected %h", rx_q[0], e); end
        end
        CONF_COL_MASK = '0;
    endtask
`endif

    initial begin
        RST_N = 1'b1;
        IN_FIFO_EMPTY = 1'b1;
        IN_FIFO_DATA = 32'h0;
        CONF_EN = 1'b0;
        CONF_TOT_MIN = 8'd0;
        CONF_TOT_MAX = 8'd255;
`ifdef MONO_HIT_FILTER_COL_MASK_EN
        CONF_COL_MASK = '0;
`endif
        OUT_FIFO_READ = 1'b0;
        #1;
        RST_N = 1'b0;
        #1;
        test_reset();
        test_window();
        test_bounds();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
`ifdef MONO_HIT_FILTER_COL_MASK_EN
        test_col_mask();
`endif
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
